eq_coeff_load_scheduler: RTL

- Shares one coefficient ROM and one write bus among the 8 band filters of the equalizer.
- Arbitrates band reload requests round-robin.
- Streams the 64 taps of the winning band from ROM into that filter's coefficient write port, then pulses that filter's write_done so the filter can commit the new set.
- Sits between the configuration/control logic and the per-band filter instances.

---
 rtl/eq_coeff_load_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/eq_coeff_load_scheduler.sv
// Coefficient load scheduler for the equalizer band filters.
// Round-robin arbitrates band reload requests, streams the winning band's taps
// from the shared coefficient ROM into that filter's write port, then pulses
// write_done/ack for one enabled cycle.
module eq_coeff_load_scheduler #(
   parameter int unsigned NUM_BANDS = 8,
   parameter int unsigned TAPS      = 64,
   parameter int unsigned COEFF_W   = 16,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned ROM_AW    = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_enable,
   input  logic [NUM_BANDS-1:0] i_req,
   output logic [NUM_BANDS-1:0] o_ack,
   output logic                 o_busy,
   output logic                 o_rom_en,
   output logic [ROM_AW-1:0]    o_rom_addr,
   input  logic [COEFF_W-1:0]   i_rom_data,
   output logic [NUM_BANDS-1:0] o_write_enable,
   output logic [ADDR_W-1:0]    o_write_address,
   output logic [COEFF_W-1:0]   o_coeffs_in,
   output logic [NUM_BANDS-1:0] o_write_done
);

   localparam int unsigned BAND_W = $clog2(NUM_BANDS);
   // Counter value of the final write-only LOAD cycle.
   localparam logic [ADDR_W:0] TapLast = (ADDR_W+1)'(TAPS);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e              state_q, state_d;
   logic [BAND_W-1:0]   band_q, band_d;
   logic [BAND_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     tap_q, tap_d;

   // Hold registers so address/data outputs stay put while their strobes are low.
   logic [ROM_AW-1:0]   rom_addr_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [COEFF_W-1:0]  coeff_q;

   logic [BAND_W-1:0]   grant;
   logic [BAND_W-1:0]   idx;
   logic                grant_valid;
   logic                rom_rd;
   logic                wr_act;
   logic [ADDR_W-1:0]   tap_prev;
   logic [NUM_BANDS-1:0] band_oh;

   // Round-robin pick: first requesting band at or after the pointer.
   always_comb begin
      grant       = ptr_q;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = 0; k < int'(NUM_BANDS); k++) begin
         idx = ptr_q + BAND_W'(k);
         if (!grant_valid && i_req[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

   // FSM state and load context registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         band_q  <= '0;
         ptr_q   <= '0;
         tap_q   <= '0;
      end else if (clk_enable) begin
         state_q <= state_d;
         band_q  <= band_d;
         ptr_q   <= ptr_d;
         tap_q   <= tap_d;
      end
   end

   // Next-state logic: grant in IDLE, count taps in LOAD, one-cycle DONE.
   always_comb begin
      state_d = state_q;
      band_d  = band_q;
      ptr_d   = ptr_q;
      tap_d   = tap_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               state_d = StLoad;
               band_d  = grant;
               ptr_d   = grant + BAND_W'(1);
               tap_d   = '0;
            end
         end
         StLoad: begin
            if (tap_q == TapLast) begin
               state_d = StDone;
            end else begin
               tap_d = tap_q + (ADDR_W+1)'(1);
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode; writes trail ROM reads by one cycle to absorb ROM latency.
   always_comb begin
      rom_rd   = (state_q == StLoad) && (tap_q != TapLast);
      wr_act   = (state_q == StLoad) && (tap_q != '0);
      // Low bits wrap to TAPS-1 on the final write cycle.
      tap_prev = tap_q[ADDR_W-1:0] - ADDR_W'(1);
      band_oh  = '0;
      band_oh[band_q] = 1'b1;

      o_busy          = (state_q != StIdle);
      o_rom_en        = rom_rd;
      o_rom_addr      = rom_rd ? {band_q, tap_q[ADDR_W-1:0]} : rom_addr_q;
      o_write_enable  = wr_act ? band_oh : '0;
      o_write_address = wr_act ? tap_prev : wr_addr_q;
      o_coeffs_in     = wr_act ? i_rom_data : coeff_q;
      o_write_done    = (state_q == StDone) ? band_oh : '0;
      o_ack           = (state_q == StDone) ? band_oh : '0;
   end

   // Capture the last driven address/data so they hold between bursts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr_q <= '0;
         wr_addr_q  <= '0;
         coeff_q    <= '0;
      end else if (clk_enable) begin
         if (rom_rd) begin
            rom_addr_q <= {band_q, tap_q[ADDR_W-1:0]};
         end
         if (wr_act) begin
            wr_addr_q <= tap_prev;
            coeff_q   <= i_rom_data;
         end
      end
   end

endmodule
